axi_lite_cmd_master: RTL
========================

Name: axi_lite_cmd_master

Overview:
Upstream stage of the AXI-Lite slave top wrapper. It converts a simple single-beat command/response interface, driven by the Verilator C++ harness or a scripted sequencer, into fully handshaked AXI-Lite master transactions on the wrapper's five channels. It handles one outstanding transaction at a time. A timeout watchdog keeps the harness from hanging on an unresponsive IP.

Parameters:
ADDR_W, 32, address width (matches C_S00_AXI_ADDR_WIDTH)
DATA_W, 32, data width (matches C_S00_AXI_DATA_WIDTH); STRB_W = DATA_W/8
TIMEOUT_CYCLES, 1024, bus-phase cycles before abort; 0 disables the watchdog
CNT_W, 16, width of the statistics counters

Ports:
clk_i  in  1  single clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block accepts command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  STRB_W  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout
rsp_timeout  out  1  transaction aborted by watchdog
write_addr / write_prot / write_addr_valid  out  ADDR_W/3/1  AW channel
write_addr_ready  in  1
write_data / write_strb / write_data_valid  out  DATA_W/STRB_W/1  W channel
write_data_ready  in  1
write_resp_ready  out  1  B channel
write_resp / write_resp_valid  in  2/1
read_addr / read_prot / read_addr_valid  out  ADDR_W/3/1  AR channel
read_addr_ready  in  1
read_data_ready  out  1  R channel
read_data / read_resp / read_data_valid  in  DATA_W/2/1
txn_count  out  CNT_W  completed responses, wraps
err_count  out  CNT_W  responses with resp != 0 or timeout, wraps

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni. Every register clears to 0 and the FSM goes to IDLE; all valid/ready outputs and cmd_ready are 0 while rst_ni = 0. All outputs are registered.
- Fixed outputs: write_prot and read_prot are always 3'b000.
- FSM states: IDLE, WR (AW+W), WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch addr, wdata, wstrb and write, and drop cmd_ready.
  - Go to WR or RD_AR; the first valid is visible on the next cycle (1-cycle latency).
- WR:
  - write_addr_valid and write_data_valid rise together.
  - Each one falls the cycle after its own valid & ready edge; AW and W complete independently, in either order or together.
  - When both are done, go to WR_B with write_resp_ready = 1.
- WR_B: on write_resp_valid & write_resp_ready, capture write_resp, drop ready, go to RSP.
- RD_AR: read_addr_valid held until read_addr_ready, then go to RD_R with read_data_ready = 1.
- RD_R: on read_data_valid, capture read_data and read_resp, drop ready, go to RSP.
- Payload stability: address, data and strobe stay stable while their valid is high.
- RSP:
  - rsp_valid = 1; all rsp_* fields stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: increment txn_count, increment err_count if rsp_resp != 0 or rsp_timeout, go to IDLE.
  - cmd_ready returns 1 on the following cycle; back-to-back commands therefore have a minimum 1 idle cycle between them.
- Watchdog:
  - Counter loads 0 on command accept and increments every cycle in WR/WR_B/RD_AR/RD_R.
  - When it reaches TIMEOUT_CYCLES-1 without the phase ending, all AXI valid/ready outputs drop on the next edge.
  - The FSM then goes to RSP with rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
  - If the completing handshake and the timeout land on the same cycle, the handshake wins and there is no timeout.
  - The abort is a simulation-harness facility only; it is not AXI-compliant.
- Late responses: a slave response arriving after an abort is ignored; its ready is held at 0.
- Counters: txn_count and err_count wrap from 2^CNT_W-1 to 0.
- Reset mid-transaction: all valids drop immediately (asynchronous) and no response is produced.

Decomposition:
- Package axi_lite_cmd_pkg holds:
  - the state enum;
  - localparams RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, PROT_DEFAULT = 3'b000.
- Sub-module axi_lite_watchdog holds the counter, the enable, the clear and the expired flag; it is reusable by future harness stages.
- Instantiate directly ahead of the slave top.

Test Plan:
- Write 0x0000_0004 data 0xDEAD_BEEF strb 4'hF; slave asserts AW and W ready the same cycle, bresp 0 -> rsp_valid with rsp_resp = 0, rsp_write = 1, txn_count = 1.
- Read 0x0000_0004 after that write, slave returns 0xDEAD_BEEF with rresp 0 -> rsp_rdata = 0xDEAD_BEEF, rsp_write = 0, addr stable throughout the AR phase.
- Write where W ready comes 3 cycles before AW ready -> write_data_valid falls first, write_addr_valid held until its ready, exactly one B accepted.
- Read where slave never asserts read_data_valid, TIMEOUT_CYCLES = 16 -> read_data_ready drops after 16 bus cycles; rsp_resp = 2'b10, rsp_timeout = 1, err_count = 1.
- Slave returns bresp 2'b10 with rsp_ready held low 5 cycles -> rsp fields stable 5 cycles, err_count increments once on acceptance.
- Assert rst_ni low while write_addr_valid = 1 -> all valids 0 asynchronously; after release cmd_ready = 1 and counters = 0.

Source files
------------

// File: rtl/axi_lite_cmd_pkg.sv
// Shared types and constants for the AXI-Lite command master and its helpers.
package axi_lite_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_watchdog.sv
// Cycle-count watchdog: counts enabled cycles since the last clear and flags
// when the final allowed cycle is reached. TIMEOUT_CYCLES = 0 never expires.
module axi_lite_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Converts single-beat command/response requests into one-at-a-time AXI-Lite
// master transactions, with a watchdog that aborts a stalled bus phase.
module axi_lite_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     write_addr,
    output logic [2:0]            write_prot,
    output logic                  write_addr_valid,
    input  logic                  write_addr_ready,
    output logic [DATA_W-1:0]     write_data,
    output logic [DATA_W/8-1:0]   write_strb,
    output logic                  write_data_valid,
    input  logic                  write_data_ready,
    output logic                  write_resp_ready,
    input  logic [1:0]            write_resp,
    input  logic                  write_resp_valid,
    output logic [ADDR_W-1:0]     read_addr,
    output logic [2:0]            read_prot,
    output logic                  read_addr_valid,
    input  logic                  read_addr_ready,
    output logic                  read_data_ready,
    input  logic [DATA_W-1:0]     read_data,
    input  logic [1:0]            read_resp,
    input  logic                  read_data_valid,
    output logic [CNT_W-1:0]      txn_count,
    output logic [CNT_W-1:0]      err_count
);

    import axi_lite_cmd_pkg::*;

    localparam int STRB_W = DATA_W / 8;

    state_t state, next_state;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic accept, aw_left, w_left, b_fire, ar_fire, r_fire, rsp_fire;
    logic abort, wd_enable, wd_expired;
    logic cmd_ready_d, aw_valid_d, w_valid_d, b_ready_d, ar_valid_d, r_ready_d, rsp_valid_d;

    assign accept   = cmd_valid & cmd_ready;
    assign aw_left  = write_addr_valid & ~write_addr_ready;
    assign w_left   = write_data_valid & ~write_data_ready;
    assign b_fire   = write_resp_valid & write_resp_ready;
    assign ar_fire  = read_addr_valid & read_addr_ready;
    assign r_fire   = read_data_valid & read_data_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    assign write_addr = addr_q;
    assign read_addr  = addr_q;
    assign write_data = wdata_q;
    assign write_strb = wstrb_q;
    assign write_prot = PROT_DEFAULT;
    assign read_prot  = PROT_DEFAULT;

    assign wd_enable = (state == ST_WR) || (state == ST_WR_B) ||
                       (state == ST_RD_AR) || (state == ST_RD_R);

    axi_lite_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (accept),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A completing handshake is checked before the watchdog so it wins a tie.
    always_comb begin
        next_state = state;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = cmd_write ? ST_WR : ST_RD_AR;
            end
            ST_WR: begin
                if (!aw_left && !w_left) begin
                    next_state = ST_WR_B;
                end else if (wd_expired) begin
                    next_state = ST_RSP;
                    abort      = 1'b1;
                end
            end
            ST_WR_B: begin
                if (b_fire) begin
                    next_state = ST_RSP;
                end else if (wd_expired) begin
                    next_state = ST_RSP;
                    abort      = 1'b1;
                end
            end
            ST_RD_AR: begin
                if (ar_fire) begin
                    next_state = ST_RD_R;
                end else if (wd_expired) begin
                    next_state = ST_RSP;
                    abort      = 1'b1;
                end
            end
            ST_RD_R: begin
                if (r_fire) begin
                    next_state = ST_RSP;
                end else if (wd_expired) begin
                    next_state = ST_RSP;
                    abort      = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_fire) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs are computed for the upcoming state and then registered.
    always_comb begin
        cmd_ready_d = (next_state == ST_IDLE);
        aw_valid_d  = (next_state == ST_WR) && ((state == ST_IDLE) || aw_left);
        w_valid_d   = (next_state == ST_WR) && ((state == ST_IDLE) || w_left);
        b_ready_d   = (next_state == ST_WR_B);
        ar_valid_d  = (next_state == ST_RD_AR);
        r_ready_d   = (next_state == ST_RD_R);
        rsp_valid_d = (next_state == ST_RSP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_ready        <= 1'b0;
            write_addr_valid <= 1'b0;
            write_data_valid <= 1'b0;
            write_resp_ready <= 1'b0;
            read_addr_valid  <= 1'b0;
            read_data_ready  <= 1'b0;
            rsp_valid        <= 1'b0;
        end else begin
            cmd_ready        <= cmd_ready_d;
            write_addr_valid <= aw_valid_d;
            write_data_valid <= w_valid_d;
            write_resp_ready <= b_ready_d;
            read_addr_valid  <= ar_valid_d;
            read_data_ready  <= r_ready_d;
            rsp_valid        <= rsp_valid_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            txn_count   <= '0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                rsp_write <= cmd_write;
            end
            if (b_fire) begin
                rsp_rdata   <= '0;
                rsp_resp    <= write_resp;
                rsp_timeout <= 1'b0;
            end else if (r_fire) begin
                rsp_rdata   <= read_data;
                rsp_resp    <= read_resp;
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_rdata   <= '0;
                rsp_resp    <= RESP_SLVERR;
                rsp_timeout <= 1'b1;
            end
            if (rsp_fire) begin
                txn_count <= txn_count + CNT_W'(1);
                if ((rsp_resp != RESP_OKAY) || rsp_timeout) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
